// File: rtl/fmul_pkg.sv
// Shared widths, saturation constant and round-robin picker for the
// time-shared fixed-point multiplier.
package fmul_pkg;
  localparam int IW     = 8;
  localparam int FW     = 8;
  localparam int NREQ   = 4;
  localparam int OPW    = IW + FW;
  localparam int PW     = 2 * OPW;
  localparam int IDW    = $clog2(NREQ);
  localparam int MAXREQ = 8;
  localparam logic [OPW-1:0] SAT = '1;

  // One-hot grant: first set bit of valid[n-1:0] searching upward from ptr with wrap.
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] valid,
                                                input int ptr, input int n);
    logic [MAXREQ-1:0] gnt;
    logic              found;
    logic [2:0]        idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAXREQ; k++) begin
      idx = 3'((ptr + k) % n);
      if (k < n && !found && valid[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/fixed_mult.sv
// Raw unsigned IW.FW x IW.FW multiply, full 2IW.2FW product.
module fixed_mult #(
  parameter int IW = fmul_pkg::IW,
  parameter int FW = fmul_pkg::FW
) (
  input  logic [IW-1:0]          ai,
  input  logic [FW-1:0]          af,
  input  logic [IW-1:0]          bi,
  input  logic [FW-1:0]          bf,
  output logic [2*(IW+FW)-1:0]   p
);
  import fmul_pkg::*;
  localparam int W = IW + FW;

  logic [2*W-1:0] a_x, b_x;

  assign a_x = {{W{1'b0}}, ai, af};
  assign b_x = {{W{1'b0}}, bi, bf};
  assign p   = a_x * b_x;
endmodule

// File: rtl/fmul_share_arb.sv
// Round-robin arbiter sharing one fixed-point multiplier among NREQ clients,
// LAT-stage pipeline with a global stall driven by response backpressure.
module fmul_share_arb #(
  parameter int NREQ = fmul_pkg::NREQ,
  parameter int IW   = fmul_pkg::IW,
  parameter int FW   = fmul_pkg::FW,
  parameter int LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*(IW+FW)-1:0]   req_a,
  input  logic [NREQ*(IW+FW)-1:0]   req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [IW+FW-1:0]          rsp_data,
  output logic                      rsp_ovf,
  output logic                      busy
);
  import fmul_pkg::*;
  localparam int OPW  = IW + FW;
  localparam int PW   = 2 * OPW;
  localparam int IDW  = $clog2(NREQ);
  // Stage that captures the product: the single register when LAT=1, else stage 2.
  localparam int RSTG = (LAT == 1) ? 1 : 2;

  logic                stall, xfer, ovf_c;
  logic [NREQ-1:0]     gnt;
  logic [IDW-1:0]      gid, rr_ptr;
  logic [MAXREQ-1:0]   v8, pick;
  logic [OPW-1:0]      ga, gb, ma, mb, res_c;
  logic [PW-1:0]       p;

  logic [LAT:1]        vld_pipe;
  logic [IDW-1:0]      id_pipe  [LAT:1];
  logic [OPW-1:0]      dat_pipe [LAT:RSTG];
  logic                ovf_pipe [LAT:RSTG];

  assign rsp_valid = vld_pipe[LAT];
  assign rsp_id    = id_pipe[LAT];
  assign rsp_data  = dat_pipe[LAT];
  assign rsp_ovf   = ovf_pipe[LAT];
  assign busy      = |vld_pipe;
  assign stall     = rsp_valid & ~rsp_ready;

  always_comb begin
    v8             = '0;
    v8[NREQ-1:0]   = req_valid;
    pick           = rr_pick(v8, int'(rr_ptr), NREQ);
    gnt            = (stall || rst) ? '0 : pick[NREQ-1:0];
    gid            = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) gid = IDW'(i);
  end

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign ga        = req_a[int'(gid)*OPW +: OPW];
  assign gb        = req_b[int'(gid)*OPW +: OPW];

  generate
    if (LAT == 1) begin : g_direct
      assign ma = ga;
      assign mb = gb;
    end else begin : g_s1
      logic [OPW-1:0] a_s1, b_s1;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_s1 <= '0;
          b_s1 <= '0;
        end else if (xfer) begin
          a_s1 <= ga;
          b_s1 <= gb;
        end
      end
      assign ma = a_s1;
      assign mb = b_s1;
    end
  endgenerate

  fixed_mult #(.IW(IW), .FW(FW)) u_fixed_mult (
    .ai (ma[OPW-1:FW]),
    .af (ma[FW-1:0]),
    .bi (mb[OPW-1:FW]),
    .bf (mb[FW-1:0]),
    .p  (p)
  );

  // Any set bit above the IW.FW window means the value cannot be represented.
  assign ovf_c = |p[PW-1:IW+2*FW];
  assign res_c = ovf_c ? '1 : p[FW +: OPW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (int'(gid) == NREQ-1) ? '0 : IDW'(gid + 1'b1);
    end
  end

  // Whole pipe freezes on stall, bubbles included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 1; k <= LAT; k++) id_pipe[k] <= '0;
      for (int k = RSTG; k <= LAT; k++) begin
        dat_pipe[k] <= '0;
        ovf_pipe[k] <= 1'b0;
      end
    end else if (!stall) begin
      vld_pipe[1]    <= xfer;
      id_pipe[1]     <= gid;
      dat_pipe[RSTG] <= res_c;
      ovf_pipe[RSTG] <= ovf_c;
      for (int k = 2; k <= LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
      for (int k = RSTG + 1; k <= LAT; k++) begin
        dat_pipe[k] <= dat_pipe[k-1];
        ovf_pipe[k] <= ovf_pipe[k-1];
      end
    end
  end
endmodule
